// File: rtl/ram_stream_reader_pkg.sv
// Shared constants for the RAM stream reader: FSM state encoding and
// the depth of the output skid FIFO.
package ram_stream_reader_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Words buffered plus reads in flight never exceed this depth.
    localparam int FIFO_DEPTH    = 2;
    localparam int FIFO_CNT_BITS = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry registered FIFO. The head register drives the stream output
// directly so there is no combinational path from push_data to head_data.
module stream_fifo2
    import ram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [RAM_WIDTH-1:0]     push_data,
    input  logic                     pop,
    output logic [RAM_WIDTH-1:0]     head_data,
    output logic                     head_valid,
    output logic [FIFO_CNT_BITS-1:0] count
);

    logic [RAM_WIDTH-1:0]     head_r;
    logic [RAM_WIDTH-1:0]     tail_r;
    logic [FIFO_CNT_BITS-1:0] count_r;

    // Storage and occupancy update; flush empties without touching data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {RAM_WIDTH{1'b0}};
            tail_r  <= {RAM_WIDTH{1'b0}};
            count_r <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r  <= push_data;
                        count_r <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_r  <= push_data;
                        count_r <= 2'd2;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= push_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign head_data  = head_r;
    assign head_valid = (count_r != 2'd0);
    assign count      = count_r;

endmodule

// File: rtl/ram_stream_reader.sv
// Read sequencer for a block RAM with a one-cycle registered read port.
// Walks a wrapping address range and re-times the words into a
// valid/ready stream through a two-entry FIFO.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS:0]   length,
    input  logic                     abort,
    output logic [RAM_ADDR_BITS-1:0] r_addr,
    input  logic [RAM_WIDTH-1:0]     r_data,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);

    logic                     state_r;
    logic                     state_next_s;
    logic [RAM_ADDR_BITS-1:0] r_addr_r;
    logic [RAM_ADDR_BITS:0]   fetch_rem_r;
    logic [RAM_ADDR_BITS:0]   emit_rem_r;
    logic                     inflight_r;
    logic                     done_r;

    logic                     accept_s;
    logic                     abort_s;
    logic                     pop_s;
    logic                     push_s;
    logic                     issue_s;
    logic                     last_s;
    logic                     done_next_s;
    logic [2:0]               occupancy_s;

    logic [FIFO_CNT_BITS-1:0] fifo_count_s;
    logic                     fifo_valid_s;
    logic [RAM_WIDTH-1:0]     fifo_head_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: abort wins over the final handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort || last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-cycle control strobes: handshake, read issue, capture, completion.
    always_comb begin
        accept_s    = 1'b0;
        abort_s     = 1'b0;
        pop_s       = fifo_valid_s && out_ready;
        push_s      = 1'b0;
        issue_s     = 1'b0;
        last_s      = 1'b0;
        done_next_s = 1'b0;
        occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        case (state_r)
            ST_IDLE: begin
                accept_s    = start && (length != {(RAM_ADDR_BITS+1){1'b0}});
                done_next_s = start && (length == {(RAM_ADDR_BITS+1){1'b0}});
            end
            ST_RUN: begin
                abort_s     = abort;
                push_s      = inflight_r && !abort;
                last_s      = pop_s && (emit_rem_r == {{RAM_ADDR_BITS{1'b0}}, 1'b1});
                issue_s     = !abort && (fetch_rem_r != {(RAM_ADDR_BITS+1){1'b0}})
                              && (occupancy_s < 3'(FIFO_DEPTH));
                done_next_s = last_s && !abort;
            end
            default: begin
                accept_s = 1'b0;
            end
        endcase
    end

    // Address walker, remaining-word counters, in-flight flag and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_r    <= {RAM_ADDR_BITS{1'b0}};
            fetch_rem_r <= {(RAM_ADDR_BITS+1){1'b0}};
            emit_rem_r  <= {(RAM_ADDR_BITS+1){1'b0}};
            inflight_r  <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= done_next_s;
            if (state_r == ST_IDLE) begin
                inflight_r <= 1'b0;
                if (accept_s) begin
                    r_addr_r    <= base_addr;
                    fetch_rem_r <= length;
                    emit_rem_r  <= length;
                end
            end else if (abort_s) begin
                inflight_r  <= 1'b0;
                fetch_rem_r <= {(RAM_ADDR_BITS+1){1'b0}};
                emit_rem_r  <= {(RAM_ADDR_BITS+1){1'b0}};
            end else begin
                inflight_r <= issue_s;
                if (issue_s) begin
                    r_addr_r    <= r_addr_r + {{(RAM_ADDR_BITS-1){1'b0}}, 1'b1};
                    fetch_rem_r <= fetch_rem_r - {{RAM_ADDR_BITS{1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    emit_rem_r <= emit_rem_r - {{RAM_ADDR_BITS{1'b0}}, 1'b1};
                end
            end
        end
    end

    stream_fifo2 #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (abort_s),
        .push       (push_s),
        .push_data  (r_data),
        .pop        (pop_s),
        .head_data  (fifo_head_s),
        .head_valid (fifo_valid_s),
        .count      (fifo_count_s)
    );

    assign r_addr    = r_addr_r;
    assign out_data  = fifo_head_s;
    assign out_valid = fifo_valid_s;
    assign busy      = (state_r == ST_RUN);
    assign done      = done_r;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ram_stream_reader;

    localparam int W     = 8;
    localparam int AB    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AB-1:0] base_addr;
    logic [AB:0]   length;
    logic          abort;
    logic [AB-1:0] r_addr;
    logic [W-1:0]  r_data;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    logic [W-1:0]  mem [DEPTH];

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (describes the upcoming cycle).
    int            m_busy, m_done, m_fetch, m_emit, m_inflight, m_inflight_addr, m_addr;
    logic [W-1:0]  m_buf [$];

    // Observed stream, collected independently of the model.
    logic [W-1:0]  got_q [$];
    int            done_cnt;
    int            valid_cnt;

    always #5 clk = ~clk;

    ram_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    // Behavioural RAM with a one-cycle registered read port.
    always @(posedge clk) r_data <= mem[r_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_fetch = 0; m_emit = 0;
        m_inflight = 0; m_inflight_addr = 0; m_addr = 0;
        m_buf.delete();
    endtask

    // Per-cycle compare against the model, then advance the model across the edge.
    always @(negedge clk) begin
        int pop, issue;
        if (!rst_n) begin
            model_reset();
        end else begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("out_valid", out_valid, m_buf.size() > 0);
            if (m_buf.size() > 0) check("out_data", out_data, m_buf[0]);
            pop   = (m_buf.size() > 0 && out_ready) ? 1 : 0;
            issue = (m_busy != 0 && !abort && m_fetch > 0 &&
                     (m_buf.size() + m_inflight - pop) < 2) ? 1 : 0;
            if (issue != 0) check("r_addr", r_addr, m_addr);
            if (m_busy != 0 && abort) begin
                m_busy = 0; m_done = 0; m_fetch = 0; m_emit = 0; m_inflight = 0;
                m_buf.delete();
            end else if (m_busy != 0) begin
                m_done = 0;
                if (pop != 0) begin
                    void'(m_buf.pop_front());
                    m_emit--;
                end
                if (m_inflight != 0) m_buf.push_back(mem[m_inflight_addr]);
                m_inflight      = issue;
                m_inflight_addr = m_addr;
                if (issue != 0) begin
                    m_addr = (m_addr + 1) % DEPTH;
                    m_fetch--;
                end
                if (pop != 0 && m_emit == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else begin
                m_done = (start && length == 0) ? 1 : 0;
                if (start && length != 0) begin
                    m_busy = 1; m_addr = int'(base_addr);
                    m_fetch = int'(length); m_emit = int'(length); m_inflight = 0;
                end
            end
        end
    end

    // Collector of accepted words, done pulses and valid cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) done_cnt++;
            if (out_valid) valid_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
    endtask

    task automatic do_start(input logic [AB-1:0] b, input logic [AB:0] l);
        start = 1'b1; base_addr = b; length = l;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_idle(input logic [31:0] pat);
        int k;
        k = 0;
        while (busy && k < 300) begin
            out_ready = pat[k % 32];
            tick();
            k++;
        end
        check("idle_timeout", busy, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic check_words(input string name, input logic [AB-1:0] b, input int n);
        check({name, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            check(name, got_q[i], 8'h10 + 8'((int'(b) + i) % DEPTH));
    endtask

    task automatic basic_run();
        int cycles;
        clear_obs();
        out_ready = 1'b1;
        do_start(4'h2, 5'd4);
        cycles = 1;
        while (!out_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        check("first_valid_latency", cycles, 3);
        run_until_idle(32'hFFFF_FFFF);
        check("basic_w0", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h12);
        check("basic_w1", got_q.size() > 1 ? got_q[1] : 8'h00, 8'h13);
        check("basic_w2", got_q.size() > 2 ? got_q[2] : 8'h00, 8'h14);
        check("basic_w3", got_q.size() > 3 ? got_q[3] : 8'h00, 8'h15);
        check("basic_done_cnt", done_cnt, 1);
    endtask

    initial begin
        int k;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h10 + 8'(i);
        clear_obs();
        model_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = 4'h0; length = 5'd0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_r_addr", r_addr, 4'h0);
        rst_n = 1'b1;
        tick();

        // Basic read.
        basic_run();

        // Wrap-around.
        clear_obs();
        do_start(4'hE, 5'd4);
        run_until_idle(32'hFFFF_FFFF);
        check("wrap_w0", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h1E);
        check("wrap_w1", got_q.size() > 1 ? got_q[1] : 8'h00, 8'h1F);
        check("wrap_w2", got_q.size() > 2 ? got_q[2] : 8'h00, 8'h10);
        check("wrap_w3", got_q.size() > 3 ? got_q[3] : 8'h00, 8'h11);

        // Backpressure with a fixed irregular ready pattern.
        clear_obs();
        do_start(4'h3, 5'd6);
        run_until_idle(32'b1011_0010_0111_0001_1100_1010_0110_1001);
        check_words("bp", 4'h3, 6);
        check("bp_done_cnt", done_cnt, 1);

        // Full depth.
        clear_obs();
        do_start(4'h5, 5'd16);
        run_until_idle(32'hFFFF_FFFF);
        check_words("full", 4'h5, 16);

        // Zero length.
        clear_obs();
        do_start(4'h7, 5'd0);
        tick();
        tick();
        tick();
        check("zero_done_cnt", done_cnt, 1);
        check("zero_valid_cnt", valid_cnt, 0);
        check("zero_busy", busy, 1'b0);

        // Abort after two words, with the consumer stalled.
        clear_obs();
        out_ready = 1'b1;
        do_start(4'h0, 5'd8);
        k = 0;
        while (got_q.size() < 2 && k < 20) begin
            tick();
            k++;
        end
        out_ready = 1'b0;
        check("abort_two_words", got_q.size(), 2);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        tick();
        tick();
        check("abort_done_cnt", done_cnt, 0);
        check_words("abort", 4'h0, 2);
        out_ready = 1'b1;
        clear_obs();
        do_start(4'h9, 5'd3);
        run_until_idle(32'hFFFF_FFFF);
        check_words("after_abort", 4'h9, 3);

        // Asynchronous reset in the middle of a transfer.
        clear_obs();
        do_start(4'h2, 5'd4);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_r_addr", r_addr, 4'h0);
        check("arst_out_data", out_data, 8'h00);
        check("arst_done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        basic_run();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
